dll_tx_packet_arbiter: RTL

Transmit-side counterpart to the DLL receive demux. It merges the DLLP source (Ack/Nak/UpdateFC generator) and the TLP source (replay/retry path) onto the single shared 1196-bit transmit bus toward the physical layer. DLLPs win arbitration by default, and a burst counter bounds how long a pending TLP can be starved. The block forwards traffic only while the DLCMSM reports DL_Active. Each transmitted word goes through one registered output stage with a valid/ready handshake.

---
 rtl/dll_pkg.sv | 23 ++
 rtl/dll_tx_out_stage.sv | 49 ++++
 rtl/dll_tx_packet_arbiter.sv | 120 ++++++++++++
 3 files changed

// File: rtl/dll_pkg.sv
// Shared DLL definitions: DLCMSM encodings, bus widths, tx arbiter states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dll_pkg;

  // DLCMSM state encodings as reported on dlc_state_i
  localparam logic [1:0] DLC_DL_INACTIVE = 2'b00;
  localparam logic [1:0] DLC_DL_FEATURE  = 2'b01;
  localparam logic [1:0] DLC_DL_INIT     = 2'b10;
  localparam logic [1:0] DLC_DL_ACTIVE   = 2'b11;

  localparam int DATA_W = 1196;
  localparam int DLLP_W = 48;

  // ST_DLLP / ST_TLP mean the output register currently holds that packet type
  typedef enum logic [1:0] {
    ST_INACTIVE,
    ST_IDLE,
    ST_DLLP,
    ST_TLP
  } arb_state_t;

endpackage

// File: rtl/dll_tx_out_stage.sv
// Single register slice for the transmit bus with a synchronous flush.
// Latency: 1 cycle from input handshake to out_vld_o.
// Backpressure: in_rdy_o = empty or draining; data/valid hold while out_rdy_i is low.
module dll_tx_out_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush_i,
  input  logic         in_vld_i,
  input  logic [W-1:0] in_dat_i,
  output logic         in_rdy_o,
  output logic         out_vld_o,
  output logic [W-1:0] out_dat_o,
  input  logic         out_rdy_i
);

  logic         vld_q, vld_d;
  logic [W-1:0] dat_q, dat_d;

  assign in_rdy_o  = !vld_q || out_rdy_i;
  assign out_vld_o = vld_q;
  assign out_dat_o = dat_q;

  // Next-state: flush clears the word; otherwise load (or go empty) whenever there is room
  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    if (flush_i) begin
      vld_d = 1'b0;
      dat_d = '0;
    end else if (in_rdy_o) begin
      vld_d = in_vld_i;
      if (in_vld_i) dat_d = in_dat_i;
    end
  end

  // Output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= 1'b0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

endmodule

// File: rtl/dll_tx_packet_arbiter.sv
// Merges DLLP and TLP sources onto the tx bus; DLLP priority with burst-bounded TLP starvation.
// Latency: 1 cycle (input handshake in N -> tx_valid_o in N+1); one packet/cycle sustained.
// Backpressure: readies low while the held word is stalled or link not DL_Active; optional
// per-type accepted-word counters under macro DLL_TX_ARB_STATS_EN.
module dll_tx_packet_arbiter #(
  parameter int DATA_W         = dll_pkg::DATA_W,
  parameter int DLLP_W         = dll_pkg::DLLP_W,
  parameter int MAX_DLLP_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        dlc_state_i,
  input  logic [DLLP_W-1:0] dllp_i,
  input  logic              dllp_valid_i,
  output logic              dllp_ready_o,
  input  logic [DATA_W-1:0] tlp_i,
  input  logic              tlp_valid_i,
  output logic              tlp_ready_o,
  output logic [DATA_W-1:0] tx_data_o,
  output logic              tx_valid_o,
  input  logic              tx_ready_i,
  output logic              tlp_fmt_err_o
`ifdef DLL_TX_ARB_STATS_EN
  ,
  output logic [31:0]       dllp_cnt_o,
  output logic [31:0]       tlp_cnt_o
`endif
);
  import dll_pkg::*;

  localparam logic [3:0] BURST_MAX = 4'(MAX_DLLP_BURST);

  arb_state_t        state_q, state_d;
  logic [3:0]        burst_q, burst_d;
  logic              fmt_err_q, fmt_err_d;
  logic              active, load, stage_rdy, tlp_first;
  logic              grant_dllp, grant_tlp, tlp_good, fwd_vld;
  logic [DATA_W-1:0] fwd_dat;

  // Arbitration, handshakes and next-state; link-down overrides everything
  always_comb begin
    active     = (dlc_state_i == DLC_DL_ACTIVE) && (state_q != ST_INACTIVE);
    load       = active && stage_rdy;
    tlp_first  = tlp_valid_i && (burst_q == BURST_MAX);
    grant_tlp  = load && tlp_valid_i && (tlp_first || !dllp_valid_i);
    grant_dllp = load && dllp_valid_i && !tlp_first;
    // A TLP with an all-zero upper field would be decoded as a DLLP downstream
    tlp_good   = |tlp_i[DATA_W-1:DLLP_W];
    fwd_vld    = grant_dllp || (grant_tlp && tlp_good);
    fwd_dat    = grant_dllp ? {{(DATA_W-DLLP_W){1'b0}}, dllp_i} : tlp_i;
    fmt_err_d  = grant_tlp && !tlp_good;

    dllp_ready_o = grant_dllp;
    tlp_ready_o  = grant_tlp;

    state_d = state_q;
    if (dlc_state_i != DLC_DL_ACTIVE) begin
      state_d = ST_INACTIVE;
    end else if (state_q == ST_INACTIVE) begin
      state_d = ST_IDLE;
    end else if (load) begin
      if (grant_dllp)                 state_d = ST_DLLP;
      else if (grant_tlp && tlp_good) state_d = ST_TLP;
      else                            state_d = ST_IDLE;
    end

    burst_d = burst_q;
    if (!active || grant_tlp || !tlp_valid_i) begin
      burst_d = 4'd0;
    end else if (grant_dllp && (burst_q != BURST_MAX)) begin
      burst_d = burst_q + 4'd1;
    end
  end

  // State, burst counter and format-error pulse registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_INACTIVE;
      burst_q   <= 4'd0;
      fmt_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      burst_q   <= burst_d;
      fmt_err_q <= fmt_err_d;
    end
  end

  assign tlp_fmt_err_o = fmt_err_q;

  dll_tx_out_stage #(.W(DATA_W)) u_out (
    .clk       (clk),
    .rst       (rst),
    .flush_i   (!active),
    .in_vld_i  (fwd_vld),
    .in_dat_i  (fwd_dat),
    .in_rdy_o  (stage_rdy),
    .out_vld_o (tx_valid_o),
    .out_dat_o (tx_data_o),
    .out_rdy_i (tx_ready_i)
  );

`ifdef DLL_TX_ARB_STATS_EN
  logic [31:0] dllp_cnt_q, tlp_cnt_q;

  // Words accepted downstream per type; survive link-down, cleared only by rst
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dllp_cnt_q <= 32'd0;
      tlp_cnt_q  <= 32'd0;
    end else if (tx_valid_o && tx_ready_i) begin
      if (state_q == ST_DLLP) dllp_cnt_q <= dllp_cnt_q + 32'd1;
      if (state_q == ST_TLP)  tlp_cnt_q  <= tlp_cnt_q + 32'd1;
    end
  end

  assign dllp_cnt_o = dllp_cnt_q;
  assign tlp_cnt_o  = tlp_cnt_q;
`endif

endmodule
